pong_ball_ctl: RTL and testbench

- Ball motion engine for the PONG game.
- Sits upstream of both paddle drawers: it produces ball_y for the AI paddle tracker and ball_x/ball_y for the ball drawer.
- Consumes the paddle top coordinates produced by the paddle drawers to detect paddle hits, wall bounces and misses.
- Emits one-cycle point pulses to the score logic.

---
 rtl/pong_ball_ctl.sv | 168 ++++++++++++++++
 tb/tb_pong_ball_ctl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctl.sv
// pong_ball_ctl: PONG ball motion engine (serve, wall bounce, paddle hit, miss scoring).
// Optional per-hit speed-up is enabled by defining PONG_BALL_SPEEDUP_EN.
module pong_ball_ctl #(
    parameter int HOR_PIXELS  = 1024,
    parameter int VER_PIXELS  = 768,
    parameter int BALL_SIZE   = 16,
    parameter int PADDLE_H    = 100,
    parameter int L_FACE_X    = 50,
    parameter int R_FACE_X    = HOR_PIXELS - 50,
    parameter int TICK_DIV    = 250000,
    parameter int SPEED       = 4,
    parameter int SERVE_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic        point_l,
    output logic        point_r
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = SERVE_TICKS > 1 ? $clog2(SERVE_TICKS) : 1;
    localparam logic [10:0] CX = 11'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [10:0] CY = 11'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [11:0] BS = 12'(BALL_SIZE);
    localparam logic [11:0] PH = 12'(PADDLE_H);
    localparam logic [11:0] LF = 12'(L_FACE_X);
    localparam logic [11:0] RF = 12'(R_FACE_X);
    localparam logic [11:0] HP = 12'(HOR_PIXELS);
    localparam logic [11:0] VP = 12'(VER_PIXELS);

    typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] serve_cnt_q, serve_cnt_d;
    logic [10:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic          point_l_q, point_l_d, point_r_q, point_r_d;
    logic [11:0]   speed;
`ifdef PONG_BALL_SPEEDUP_EN
    logic [11:0]   speed_q, speed_d;
    assign speed = speed_q;
`else
    assign speed = 12'(SPEED);
`endif

    logic          tick;
    logic [11:0]   bx, by, ply, pry;
    logic          bot, top, hit_r, hit_l, miss_r, miss_l, dy_step, dx_step;
    logic [10:0]   x_step, y_step;

    assign tick       = tick_cnt_q == TW'(TICK_DIV - 1);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // One motion step evaluated from the current ball state and sampled paddles.
    always_comb begin
        bx      = {1'b0, ball_x_q};
        by      = {1'b0, ball_y_q};
        ply     = {1'b0, paddle_l_y};
        pry     = {1'b0, paddle_r_y};
        bot     = by + BS + speed >= VP;
        top     = by < speed;
        hit_r   = dir_x_q && (bx + BS <= RF) && (bx + BS + speed >= RF) && (by + BS > pry) && (by < pry + PH);
        hit_l   = !dir_x_q && (bx >= LF) && (bx < LF + speed) && (by + BS > ply) && (by < ply + PH);
        miss_r  = dir_x_q && !hit_r && (bx + BS + speed >= HP);
        miss_l  = !dir_x_q && !hit_l && (bx < speed);
        y_step  = dir_y_q ? (bot ? 11'(VP - BS) : 11'(by + speed)) : (top ? 11'd0 : 11'(by - speed));
        dy_step = dir_y_q ? !bot : top;
        x_step  = hit_r ? 11'(RF - BS) : hit_l ? 11'(LF) : dir_x_q ? 11'(bx + speed) : 11'(bx - speed);
        dx_step = hit_r ? 1'b0 : hit_l ? 1'b1 : dir_x_q;
    end

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            serve_cnt_q <= '0;
            ball_x_q    <= CX;
            ball_y_q    <= CY;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            point_l_q   <= 1'b0;
            point_r_q   <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
            speed_q     <= 12'(SPEED);
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            point_l_q   <= point_l_d;
            point_r_q   <= point_r_d;
`ifdef PONG_BALL_SPEEDUP_EN
            speed_q     <= speed_d;
`endif
        end
    end

    // Next state: serve countdown in ticks, a miss ends the rally for one cycle.
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d     = SERVE;
                serve_cnt_d = '0;
            end
            SERVE: if (tick) begin
                serve_cnt_d = serve_cnt_q + 1'b1;
                if (serve_cnt_q == SW'(SERVE_TICKS - 1)) state_d = MOVE;
            end
            MOVE: if (tick && (miss_r || miss_l)) state_d = SCORED;
            default: begin
                state_d     = SERVE;
                serve_cnt_d = '0;
            end
        endcase
    end

    // Outputs: apply the motion step on ticks in MOVE, recentre toward the conceding side on SCORED.
    always_comb begin
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        point_l_d = 1'b0;
        point_r_d = 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
        speed_d   = speed_q;
`endif
        if (state_q == MOVE && tick) begin
            ball_y_d  = y_step;
            dir_y_d   = dy_step;
            ball_x_d  = (miss_r || miss_l) ? ball_x_q : x_step;
            dir_x_d   = (miss_r || miss_l) ? dir_x_q : dx_step;
            point_l_d = miss_r;
            point_r_d = miss_l;
`ifdef PONG_BALL_SPEEDUP_EN
            speed_d   = ((hit_r || hit_l) && speed_q < 12'(2 * SPEED)) ? speed_q + 12'd1 : speed_q;
`endif
        end else if (state_q == SCORED) begin
            ball_x_d = CX;
            ball_y_d = CY;
            dir_x_d  = point_l_q;
`ifdef PONG_BALL_SPEEDUP_EN
            speed_d  = 12'(SPEED);
`endif
        end
    end

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign dir_x   = dir_x_q;
    assign dir_y   = dir_y_q;
    assign point_l = point_l_q;
    assign point_r = point_r_q;
endmodule

// File: tb/tb_pong_ball_ctl.sv
// tb_pong_ball_ctl: randomized bench for pong_ball_ctl against a cycle-level game model.
module tb_pong_ball_ctl;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int SP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] paddle_l_y = '0;
    logic [10:0] paddle_r_y = '0;
    logic [10:0] ball_x, ball_y;
    logic        dir_x, dir_y, point_l, point_r;

    int checks = 0;
    int failures = 0;
    int pmode = 0;

    int m_x, m_y, m_dx, m_dy, m_pl, m_pr, m_sp, m_mode, m_scnt, m_cyc, m_ticks;

    pong_ball_ctl #(.TICK_DIV(TD), .SERVE_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .point_l(point_l), .point_r(point_r)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game model: mode 0 idle, 1 serve, 2 move, 3 scored.
    task automatic m_reset();
        m_x = 504; m_y = 376; m_dx = 1; m_dy = 1; m_pl = 0; m_pr = 0;
        m_sp = SP; m_mode = 0; m_scnt = 0; m_cyc = 0; m_ticks = 0;
    endtask

    task automatic m_move();
        int pl = int'(paddle_l_y);
        int pr = int'(paddle_r_y);
        bit rh = m_dx == 1 && m_x + 16 <= 974 && m_x + 16 + m_sp >= 974 && m_y + 16 > pr && m_y < pr + 100;
        bit lh = m_dx == 0 && m_x >= 50 && m_x < 50 + m_sp && m_y + 16 > pl && m_y < pl + 100;
        if (m_dy == 1 && m_y + 16 + m_sp >= 768) begin m_y = 752; m_dy = 0; end
        else if (m_dy == 0 && m_y < m_sp) begin m_y = 0; m_dy = 1; end
        else m_y = m_dy == 1 ? m_y + m_sp : m_y - m_sp;
        if (rh) begin m_x = 958; m_dx = 0; end
        else if (lh) begin m_x = 50; m_dx = 1; end
        else if (m_dx == 1 && m_x + 16 + m_sp >= 1024) begin m_pl = 1; m_mode = 3; end
        else if (m_dx == 0 && m_x < m_sp) begin m_pr = 1; m_mode = 3; end
        else m_x = m_dx == 1 ? m_x + m_sp : m_x - m_sp;
`ifdef PONG_BALL_SPEEDUP_EN
        if ((rh || lh) && m_sp < 2 * SP) m_sp++;
`endif
    endtask

    task automatic m_edge();
        bit tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        if (tick) m_ticks++;
        if (m_mode == 3) begin
            m_x = 504; m_y = 376; m_dx = m_pl; m_sp = SP;
            m_pl = 0; m_pr = 0; m_mode = 1; m_scnt = 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_scnt = 0; end
        end else if (m_mode == 1) begin
            if (tick) begin
                if (m_scnt == ST - 1) m_mode = 2;
                m_scnt++;
            end
        end else if (tick) m_move();
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_edge();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("ball_x", int'(ball_x), m_x);
        chk("ball_y", int'(ball_y), m_y);
        chk("dir_x", int'(dir_x), m_dx);
        chk("dir_y", int'(dir_y), m_dy);
        chk("point_l", int'(point_l), m_pl);
        chk("point_r", int'(point_r), m_pr);
    end

    function automatic logic [10:0] track(int off);
        int v = m_y - off;
        return 11'(v < 0 ? 0 : v);
    endfunction

    // Paddle stimulus; changes every cycle so only tick-cycle values may matter.
    initial forever begin
        @(negedge clk);
        case (pmode)
            1: begin paddle_r_y = track(20); paddle_l_y = 11'($urandom_range(0, 767)); end
            2: begin paddle_l_y = m_y < 384 ? 11'd600 : 11'd0; paddle_r_y = 11'($urandom_range(0, 767)); end
            3: begin paddle_l_y = track(20); paddle_r_y = m_y < 384 ? 11'd600 : 11'd0; end
            4: begin
                paddle_l_y = $urandom_range(0, 3) == 0 ? 11'($urandom_range(0, 767)) : track($urandom_range(0, 90));
                paddle_r_y = $urandom_range(0, 3) == 0 ? 11'($urandom_range(0, 767)) : track($urandom_range(0, 90));
            end
            default: begin paddle_l_y = 11'($urandom_range(0, 767)); paddle_r_y = 11'($urandom_range(0, 767)); end
        endcase
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int t0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_x", int'(ball_x), 504);
        chk("idle_y", int'(ball_y), 376);
        chk("idle_dir_x", int'(dir_x), 1);
        chk("idle_dir_y", int'(dir_y), 1);
        chk("idle_points", int'({point_l, point_r}), 0);

        pmode = 1;
        pulse_start();
        t0 = m_ticks;
        n = 0;
        while (ball_x == 11'd504 && n < 200) begin @(negedge clk); n++; end
        chk("first_move_x", int'(ball_x), 508);
        chk("first_move_y", int'(ball_y), 380);
        chk("first_move_tick", m_ticks - t0, 3);

        n = 0;
        while (!(ball_y == 11'd748 && dir_y) && n < 5000) begin @(negedge clk); n++; end
        chk("reach_y748", int'(n < 5000), 1);
        n = 0;
        while (ball_y == 11'd748 && n < 100) begin @(negedge clk); n++; end
        chk("bottom_y", int'(ball_y), 752);
        chk("bottom_dir_y", int'(dir_y), 0);

        n = 0;
        while (!(ball_x == 11'd956 && dir_x) && n < 5000) begin @(negedge clk); n++; end
        chk("reach_x956", int'(n < 5000), 1);
        n = 0;
        while (ball_x == 11'd956 && n < 100) begin @(negedge clk); n++; end
        chk("rhit_x", int'(ball_x), 958);
        chk("rhit_dir_x", int'(dir_x), 0);

        pmode = 2;
        n = 0;
        while (!point_r && n < 10000) begin @(negedge clk); n++; end
        chk("lmiss_point_r", int'(point_r), 1);
        chk("lmiss_point_l", int'(point_l), 0);
        @(negedge clk);
        chk("lmiss_pulse_width", int'(point_r), 0);
        chk("lmiss_recentre_x", int'(ball_x), 504);
        chk("lmiss_recentre_y", int'(ball_y), 376);
        chk("lmiss_dir_x", int'(dir_x), 0);

        pmode = 3;
        n = 0;
        while (!point_l && n < 10000) begin @(negedge clk); n++; end
        chk("rmiss_point_l", int'(point_l), 1);
        chk("rmiss_point_r", int'(point_r), 0);
        @(negedge clk);
        chk("rmiss_pulse_width", int'(point_l), 0);
        chk("rmiss_recentre_x", int'(ball_x), 504);
        chk("rmiss_recentre_y", int'(ball_y), 376);
        chk("rmiss_dir_x", int'(dir_x), 1);

        pmode = 4;
        repeat (20000) @(negedge clk);

        n = 0;
        while (m_mode != 2 && n < 2000) begin @(negedge clk); n++; end
        chk("in_move_before_reset", m_mode, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", int'(ball_x), 504);
        chk("async_rst_y", int'(ball_y), 376);
        chk("async_rst_dir", int'({dir_x, dir_y}), 3);
        chk("async_rst_points", int'({point_l, point_r}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (6000) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
